// File: rtl/gen_datapath.sv
// gen_datapath: single-bus accumulator datapath with PC, MAR/MDR, RAM, GPR file and ALU.
// Define FLAG_REG_EN to hold zero/carry in registers updated by load_flags.
module gen_datapath #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_GPR = 4
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic [2:0]                 bus_src,
    input  logic [$clog2(NUM_GPR)-1:0] gpr_sel,
    input  logic                       load_accum,
    input  logic                       load_temp,
    input  logic                       load_mar,
    input  logic                       load_mdr,
    input  logic                       load_ir,
    input  logic                       load_gpr,
    input  logic                       load_out,
    input  logic                       load_pc,
    input  logic                       count_pc,
    input  logic                       ram_we,
    input  logic                       load_flags,
    input  logic                       mdr_from_bus,
    input  logic [1:0]                 alu_op,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          bus,
    output logic [DATA_W-1:0]          data_out,
    output logic [DATA_W-1:0]          ir_out,
    output logic                       zero_flag,
    output logic                       carry_flag
);

    localparam int GW    = $clog2(NUM_GPR);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [GW-1:0]     GPR_LAST = GW'(NUM_GPR - 1);
    localparam logic [DATA_W:0]   SUB_ONE  = 1;
    localparam logic [ADDR_W-1:0] PC_ONE   = 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d, accum_q, accum_d, temp_q, temp_d;
    logic [DATA_W-1:0] ir_q, ir_d, out_q, out_d;
    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              raw_zero, raw_carry, gpr_ok;

    always_comb begin
        unique case (alu_op)
            2'b00:   sum = {1'b0, accum_q} + {1'b0, temp_q};
            2'b01:   sum = {1'b0, accum_q} + {1'b0, ~temp_q} + SUB_ONE;
            2'b10:   sum = {1'b0, accum_q & temp_q};
            default: sum = {1'b0, accum_q ^ temp_q};
        endcase
    end

    assign alu_res   = sum[DATA_W-1:0];
    assign raw_carry = sum[DATA_W];
    assign raw_zero  = (alu_res == '0);
    // Non-power-of-two GPR counts leave unused gpr_sel codes; treat them as absent.
    assign gpr_ok    = (gpr_sel <= GPR_LAST);

    always_comb begin
        unique case (bus_src)
            3'd0:    bus = '0;
            3'd1:    bus = data_in;
            3'd2:    bus = accum_q;
            3'd3:    bus = alu_res;
            3'd4:    bus = DATA_W'(pc_q);
            3'd5:    bus = mdr_q;
            3'd6:    bus = gpr_ok ? gpr_q[gpr_sel] : '0;
            default: bus = ir_q;
        endcase
    end

    always_comb begin
        accum_d = load_accum ? bus : accum_q;
        temp_d  = load_temp  ? bus : temp_q;
        ir_d    = load_ir    ? bus : ir_q;
        out_d   = load_out   ? bus : out_q;
        mar_d   = load_mar   ? ADDR_W'(bus) : mar_q;
        mdr_d   = mdr_q;
        if (load_mdr) mdr_d = mdr_from_bus ? bus : mem[mar_q];
        pc_d = pc_q;
        if (load_pc)       pc_d = ADDR_W'(bus);
        else if (count_pc) pc_d = pc_q + PC_ONE;
        for (int i = 0; i < NUM_GPR; i++) gpr_d[i] = gpr_q[i];
        if (load_gpr && gpr_ok) gpr_d[gpr_sel] = bus;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            pc_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            accum_q <= '0;
            temp_q  <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            accum_q <= accum_d;
            temp_q  <= temp_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
        end
    end

    // RAM keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (clear_n && ram_we) mem[mar_q] <= mdr_q;
    end

    assign data_out = out_q;
    assign ir_out   = ir_q;

`ifdef FLAG_REG_EN
    logic zf_q, zf_d, cf_q, cf_d;

    always_comb begin
        zf_d = zf_q;
        cf_d = cf_q;
        if (load_flags) begin
            zf_d = raw_zero;
            cf_d = raw_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            cf_q <= cf_d;
        end
    end

    assign zero_flag  = zf_q;
    assign carry_flag = cf_q;
`else
    logic unused_load_flags;
    assign unused_load_flags = load_flags;
    assign zero_flag  = raw_zero;
    assign carry_flag = raw_carry;
`endif

endmodule
